// File: rtl/cyclic_bram_repeat.sv
// rtl/cyclic_bram_repeat.sv - fill-once BRAM replayed cyclically for a programmable number of passes
module cyclic_bram_repeat #(
    parameter int DEPTH      = 8,
    parameter int WIDTH      = 64,
    parameter int LATENCY    = 3,
    parameter int REP_WIDTH  = 8,
    parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    input  logic [ADDR_WIDTH-1:0] addr_max_1,
    input  logic [REP_WIDTH-1:0]  repeats_1,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WIDTH-1:0]      s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTH-1:0]      m_data,
    output logic                  m_pass_last,
    output logic                  m_last
);
    localparam int FD = LATENCY + 1;
    localparam int PW = $clog2(FD);
    localparam int CW = $clog2(FD + 1);
    localparam logic [0:0] ST_WRITE = 1'b0;
    localparam logic [0:0] ST_READ  = 1'b1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d, amax_q, amax_d, r_addr_q, r_addr_d;
    logic [REP_WIDTH-1:0]  rep_q, rep_d, pass_q, pass_d;
    logic                  done_q, done_d;
    logic [CW-1:0]         credit_q, credit_d;

    logic                  pv_q [LATENCY];
    logic                  pp_q [LATENCY];
    logic                  pl_q [LATENCY];
    logic [WIDTH-1:0]      pd_q [LATENCY];

    logic [WIDTH-1:0]      fd_q [FD];
    logic                  fp_q [FD];
    logic                  fl_q [FD];
    logic [PW-1:0]         wp_q, rp_q;
    logic [CW-1:0]         cnt_q;

    logic [ADDR_WIDTH-1:0] amax_in, cur_amax;
    logic                  s_acc, issue, iss_pass, iss_last;
    logic                  pipe_v, fifo_empty, out_v, out_p, out_l, out_acc, push, pop;
    logic [WIDTH-1:0]      out_d;

    if ((1 << ADDR_WIDTH) > DEPTH) begin : g_sat
        assign amax_in = (addr_max_1 > ADDR_WIDTH'(DEPTH - 1)) ? ADDR_WIDTH'(DEPTH - 1) : addr_max_1;
    end else begin : g_nosat
        assign amax_in = addr_max_1;
    end

    // The first beat compares against the live config since it is latched on that same edge.
    assign cur_amax   = (w_addr_q == '0) ? amax_in : amax_q;
    assign s_acc      = (state_q == ST_WRITE) && s_valid;
    assign issue      = (state_q == ST_READ) && !done_q && (credit_q < CW'(FD));
    assign iss_pass   = (r_addr_q == amax_q);
    assign iss_last   = iss_pass && (pass_q == rep_q);

    // Fall-through FIFO: the pipeline head is presented directly while the FIFO is empty.
    assign pipe_v     = pv_q[LATENCY-1];
    assign fifo_empty = (cnt_q == '0);
    assign out_v      = !fifo_empty || pipe_v;
    assign out_d      = fifo_empty ? pd_q[LATENCY-1] : fd_q[rp_q];
    assign out_p      = fifo_empty ? pp_q[LATENCY-1] : fp_q[rp_q];
    assign out_l      = fifo_empty ? pl_q[LATENCY-1] : fl_q[rp_q];
    assign out_acc    = out_v && m_ready;
    assign push       = pipe_v && !(fifo_empty && m_ready);
    assign pop        = out_acc && !fifo_empty;

    assign s_ready     = !reset && (state_q == ST_WRITE);
    assign m_valid     = !reset && out_v;
    assign m_data      = m_valid ? out_d : '0;
    assign m_pass_last = m_valid && out_p;
    assign m_last      = m_valid && out_l;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        state_d  = state_q;
        w_addr_d = w_addr_q;
        amax_d   = amax_q;
        rep_d    = rep_q;
        r_addr_d = r_addr_q;
        pass_d   = pass_q;
        done_d   = done_q;
        credit_d = credit_q + CW'(issue) - CW'(out_acc);
        if (s_acc) begin
            w_addr_d = w_addr_q + ADDR_WIDTH'(1);
            if (w_addr_q == '0) begin
                amax_d = amax_in;
                rep_d  = repeats_1;
            end
            if (w_addr_q == cur_amax) begin
                state_d  = ST_READ;
                w_addr_d = '0;
            end
        end
        if (issue) begin
            if (iss_last) begin
                done_d = 1'b1;
            end else if (iss_pass) begin
                r_addr_d = '0;
                pass_d   = pass_q + REP_WIDTH'(1);
            end else begin
                r_addr_d = r_addr_q + ADDR_WIDTH'(1);
            end
        end
        if (out_acc && out_l) begin
            state_d  = ST_WRITE;
            r_addr_d = '0;
            pass_d   = '0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_WRITE;
            w_addr_q <= '0;
            amax_q   <= '0;
            rep_q    <= '0;
            r_addr_q <= '0;
            pass_q   <= '0;
            done_q   <= 1'b0;
            credit_q <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            for (int k = 0; k < LATENCY; k++) pv_q[k] <= 1'b0;
        end else if (clken) begin
            state_q  <= state_d;
            w_addr_q <= w_addr_d;
            amax_q   <= amax_d;
            rep_q    <= rep_d;
            r_addr_q <= r_addr_d;
            pass_q   <= pass_d;
            done_q   <= done_d;
            credit_q <= credit_d;
            pv_q[0]  <= issue;
            for (int k = 1; k < LATENCY; k++) pv_q[k] <= pv_q[k-1];
            if (push) wp_q <= ptr_inc(wp_q);
            if (pop)  rp_q <= ptr_inc(rp_q);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (clken) begin
            if (s_acc && !reset) mem[w_addr_q] <= s_data;
            pd_q[0] <= mem[r_addr_q];
            pp_q[0] <= iss_pass;
            pl_q[0] <= iss_last;
            for (int k = 1; k < LATENCY; k++) begin
                pd_q[k] <= pd_q[k-1];
                pp_q[k] <= pp_q[k-1];
                pl_q[k] <= pl_q[k-1];
            end
            if (push) begin
                fd_q[wp_q] <= pd_q[LATENCY-1];
                fp_q[wp_q] <= pp_q[LATENCY-1];
                fl_q[wp_q] <= pl_q[LATENCY-1];
            end
        end
    end
endmodule

// File: tb/tb_cyclic_bram_repeat.sv
// tb/tb_cyclic_bram_repeat.sv - self-checking bench for cyclic_bram_repeat
module tb_cyclic_bram_repeat;
    localparam int DEPTH = 8, WIDTH = 64, LATENCY = 3, REP_WIDTH = 8, AW = 3;

    logic             clk = 1'b0;
    logic             reset, clken, s_valid, s_ready, m_valid, m_ready, m_pass_last, m_last;
    logic [AW-1:0]    addr_max_1;
    logic [REP_WIDTH-1:0] repeats_1;
    logic [WIDTH-1:0] s_data, m_data;

    int checks = 0, errors = 0;
    logic [WIDTH-1:0] wdata[$];
    logic [WIDTH-1:0] exp_d[$];
    bit               exp_p[$], exp_l[$];
    logic [WIDTH-1:0] ed;
    bit               ep, el;

    always #5 clk = ~clk;

    cyclic_bram_repeat #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LATENCY(LATENCY), .REP_WIDTH(REP_WIDTH)) dut (
        .clk(clk), .reset(reset), .clken(clken), .addr_max_1(addr_max_1), .repeats_1(repeats_1),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_pass_last(m_pass_last), .m_last(m_last)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected replay: words 0..amax repeated rep+1 times, flags from position.
    task automatic build_exp(input int amax, input int rep);
        exp_d.delete(); exp_p.delete(); exp_l.delete();
        for (int p = 0; p <= rep; p++)
            for (int a = 0; a <= amax; a++) begin
                exp_d.push_back(wdata[a]);
                exp_p.push_back(a == amax);
                exp_l.push_back(a == amax && p == rep);
            end
    endtask

    task automatic fill(input int amax, input int rep, input int gap_at, input int gap_pct);
        addr_max_1 = AW'(amax);
        repeats_1  = REP_WIDTH'(rep);
        for (int i = 0; i < wdata.size(); i++) begin
            if (i == gap_at) begin s_valid = 1'b0; step(); end
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin s_valid = 1'b0; step(); end
            s_valid = 1'b1;
            s_data  = wdata[i];
            step();
            if (i == 0) begin addr_max_1 = AW'($urandom); repeats_1 = REP_WIDTH'($urandom); end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; clken = 1'b1; s_valid = 1'b1; m_ready = 1'b1; s_data = '1;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if ({s_ready, m_valid, m_pass_last, m_last} !== 4'b0000 || m_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got s_ready=%b m_valid=%b pass=%b last=%b data=%0h, expected all 0",
                     s_ready, m_valid, m_pass_last, m_last, m_data);
        end
        step();
        reset = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got s_ready=%b m_valid=%b, expected 1 0", s_ready, m_valid);
        end
        step();
    endtask

    task automatic test_fill_replay();
        int first = -1, bubble = 0, sr_bad = 0;
        bit done = 0;
        wdata = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6};
        build_exp(5, 1);
        m_ready = 1'b1;
        fill(5, 1, 2, 0);
        for (int i = 1; i <= 60 && !done; i++) begin
            @(negedge clk);
            if (m_valid && first < 0) first = i;
            if (first > 0 && !m_valid) bubble++;
            if (s_ready) sr_bad++;
            if (m_valid) begin
                checks++;
                if (exp_d.size() == 0) begin
                    errors++; $display("FAIL fill_extra: got word %0h, expected none", m_data);
                end else begin
                    ed = exp_d.pop_front(); ep = exp_p.pop_front(); el = exp_l.pop_front();
                    if ({m_data, m_pass_last, m_last} !== {ed, ep, el}) begin
                        errors++;
                        $display("FAIL fill_word: got %0h/%b/%b, expected %0h/%b/%b", m_data, m_pass_last, m_last, ed, ep, el);
                    end
                end
                if (m_last) done = 1;
            end
            step();
        end
        checks++;
        if (!done || exp_d.size() != 0) begin
            errors++; $display("FAIL fill_complete: got done=%0d remaining=%0d, expected 1 0", done, exp_d.size());
        end
        checks++;
        if (first != LATENCY + 1) begin
            errors++; $display("FAIL fill_latency: got %0d cycles, expected %0d", first, LATENCY + 1);
        end
        checks++;
        if (bubble != 0) begin
            errors++; $display("FAIL fill_bubbles: got %0d, expected 0", bubble);
        end
        checks++;
        if (sr_bad != 0) begin
            errors++; $display("FAIL fill_sready_read: got %0d cycles with s_ready=1, expected 0", sr_bad);
        end
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++; $display("FAIL fill_return: got s_ready=%b m_valid=%b, expected 1 0", s_ready, m_valid);
        end
        step();
    endtask

    task automatic test_backpressure();
        bit pat [8] = '{1, 1, 0, 0, 1, 0, 1, 1};
        bit done = 0, stall = 0;
        logic [WIDTH-1:0] sd;
        bit sp, sl;
        wdata = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6};
        build_exp(5, 1);
        fill(5, 1, 2, 0);
        for (int i = 0; i < 200 && !done; i++) begin
            m_ready = pat[i % 8];
            @(negedge clk);
            if (stall) begin
                checks++;
                if (m_valid !== 1'b1 || {m_data, m_pass_last, m_last} !== {sd, sp, sl}) begin
                    errors++;
                    $display("FAIL bp_stable: got v=%b %0h/%b/%b, expected v=1 %0h/%b/%b", m_valid, m_data, m_pass_last, m_last, sd, sp, sl);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_d.size() == 0) begin
                    errors++; $display("FAIL bp_extra: got word %0h, expected none", m_data);
                end else begin
                    ed = exp_d.pop_front(); ep = exp_p.pop_front(); el = exp_l.pop_front();
                    if ({m_data, m_pass_last, m_last} !== {ed, ep, el}) begin
                        errors++;
                        $display("FAIL bp_word: got %0h/%b/%b, expected %0h/%b/%b", m_data, m_pass_last, m_last, ed, ep, el);
                    end
                end
                if (m_last) done = 1;
            end
            stall = m_valid && !m_ready;
            sd = m_data; sp = m_pass_last; sl = m_last;
            step();
        end
        checks++;
        if (!done || exp_d.size() != 0) begin
            errors++; $display("FAIL bp_complete: got done=%0d remaining=%0d, expected 1 0", done, exp_d.size());
        end
    endtask

    task automatic test_min_case();
        bit done = 0;
        wdata = '{64'hA5};
        m_ready = 1'b1;
        fill(0, 0, -1, 0);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (m_valid) begin
                done = 1;
                checks++;
                if ({m_data, m_pass_last, m_last} !== {64'hA5, 1'b1, 1'b1}) begin
                    errors++; $display("FAIL min_word: got %0h/%b/%b, expected a5/1/1", m_data, m_pass_last, m_last);
                end
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (!done || s_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++; $display("FAIL min_return: got done=%0d s_ready=%b m_valid=%b, expected 1 1 0", done, s_ready, m_valid);
        end
        step();
    endtask

    task automatic test_clken_freeze();
        bit done = 0;
        int nx = 0, frz = 0;
        logic [WIDTH-1:0] sd;
        bit sv, sp, sl, sr;
        wdata.delete();
        for (int i = 0; i < 6; i++) wdata.push_back({$urandom, $urandom});
        build_exp(5, 1);
        m_ready = 1'b1;
        fill(5, 1, -1, 0);
        for (int i = 0; i < 200 && !done; i++) begin
            clken = (frz > 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (frz == 4) begin
                sv = m_valid; sd = m_data; sp = m_pass_last; sl = m_last; sr = s_ready;
                checks++;
                if (m_valid !== 1'b1 || m_data !== exp_d[0]) begin
                    errors++; $display("FAIL frz_head: got v=%b %0h, expected v=1 %0h", m_valid, m_data, exp_d[0]);
                end
            end else if (frz > 0) begin
                checks++;
                if ({m_valid, m_data, m_pass_last, m_last, s_ready} !== {sv, sd, sp, sl, sr}) begin
                    errors++; $display("FAIL frz_hold: got v=%b %0h/%b/%b, expected v=%b %0h/%b/%b", m_valid, m_data, m_pass_last, m_last, sv, sd, sp, sl);
                end
            end
            if (frz > 0) frz--;
            else if (m_valid && m_ready) begin
                checks++;
                if (exp_d.size() == 0) begin
                    errors++; $display("FAIL frz_extra: got word %0h, expected none", m_data);
                end else begin
                    ed = exp_d.pop_front(); ep = exp_p.pop_front(); el = exp_l.pop_front();
                    if ({m_data, m_pass_last, m_last} !== {ed, ep, el}) begin
                        errors++;
                        $display("FAIL frz_word: got %0h/%b/%b, expected %0h/%b/%b", m_data, m_pass_last, m_last, ed, ep, el);
                    end
                end
                nx++;
                if (nx == 3) frz = 4;
                if (m_last) done = 1;
            end
            step();
        end
        clken = 1'b1;
        checks++;
        if (!done || exp_d.size() != 0) begin
            errors++; $display("FAIL frz_complete: got done=%0d remaining=%0d, expected 1 0", done, exp_d.size());
        end
    endtask

    task automatic test_reset_mid_read();
        bit done = 0;
        int nx = 0;
        wdata.delete();
        for (int i = 0; i < 6; i++) wdata.push_back({$urandom, $urandom});
        m_ready = 1'b1;
        fill(5, 2, -1, 0);
        for (int i = 0; i < 40 && nx < 3; i++) begin
            @(negedge clk);
            if (m_valid) nx++;
            step();
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_valid, s_ready, m_last} !== 3'b000 || m_data !== '0) begin
            errors++; $display("FAIL rst_mid_during: got v=%b s_ready=%b last=%b data=%0h, expected 0 0 0 0", m_valid, s_ready, m_last, m_data);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_after: got v=%b s_ready=%b, expected 0 1", m_valid, s_ready);
        end
        step();
        wdata = '{64'd10, 64'd11, 64'd12, 64'd13};
        build_exp(3, 0);
        fill(3, 0, -1, 0);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (m_valid) begin
                checks++;
                if (exp_d.size() == 0) begin
                    errors++; $display("FAIL refill_extra: got word %0h, expected none", m_data);
                end else begin
                    ed = exp_d.pop_front(); ep = exp_p.pop_front(); el = exp_l.pop_front();
                    if ({m_data, m_pass_last, m_last} !== {ed, ep, el}) begin
                        errors++;
                        $display("FAIL refill_word: got %0h/%b/%b, expected %0h/%b/%b", m_data, m_pass_last, m_last, ed, ep, el);
                    end
                end
                if (m_last) done = 1;
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (!done || exp_d.size() != 0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL refill_complete: got done=%0d remaining=%0d v=%b, expected 1 0 0", done, exp_d.size(), m_valid);
        end
        step();
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int amax = $urandom_range(0, DEPTH - 1);
            int rep  = $urandom_range(0, 3);
            int sr_bad = 0;
            bit done = 0;
            wdata.delete();
            for (int i = 0; i <= amax; i++) wdata.push_back({$urandom, $urandom});
            build_exp(amax, rep);
            fill(amax, rep, -1, 30);
            for (int i = 0; i < 400 && !done; i++) begin
                m_ready = ($urandom_range(99) < 70);
                s_valid = $urandom_range(1);
                s_data  = {$urandom, $urandom};
                @(negedge clk);
                if (s_ready) sr_bad++;
                if (m_valid && m_ready) begin
                    checks++;
                    if (exp_d.size() == 0) begin
                        errors++; $display("FAIL rnd_extra: got word %0h, expected none", m_data);
                    end else begin
                        ed = exp_d.pop_front(); ep = exp_p.pop_front(); el = exp_l.pop_front();
                        if ({m_data, m_pass_last, m_last} !== {ed, ep, el}) begin
                            errors++;
                            $display("FAIL rnd_word: got %0h/%b/%b, expected %0h/%b/%b", m_data, m_pass_last, m_last, ed, ep, el);
                        end
                    end
                    if (m_last) done = 1;
                end
                step();
            end
            s_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (!done || exp_d.size() != 0 || sr_bad != 0 || s_ready !== 1'b1 || m_valid !== 1'b0) begin
                errors++;
                $display("FAIL rnd_complete: got done=%0d remaining=%0d sr_bad=%0d s_ready=%b v=%b, expected 1 0 0 1 0",
                         done, exp_d.size(), sr_bad, s_ready, m_valid);
            end
            step();
        end
    endtask

    initial begin
        reset = 1'b1; clken = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        s_data = '0; addr_max_1 = '0; repeats_1 = '0;
        test_reset();
        test_fill_replay();
        test_backpressure();
        test_min_case();
        test_clken_freeze();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
